// File: rtl/sdec_loop_seq.sv
// sdec_loop_seq: signed down-counting loop sequencer.
//
// Emits the index stream N, N-1, ..., 1 over a valid/ready handshake for a start count N.
// The decrement itself is done by an external SDEC instance: this block drives its operand
// (dec_a) from the current index register and loads its result (dec_d) as the next index.
// A one-cycle done pulse follows the last accepted index. A start count of zero or below
// skips straight to done without emitting any index.
//
// Ports:
//   Clk        clock, rising edge
//   Rst        asynchronous active-low reset
//   start      load request, honoured only when idle
//   count      signed loop count, sampled with start
//   abort      cancel a running loop (no done pulse)
//   idx        current index (registered)
//   idx_valid  idx holds a valid index
//   idx_ready  consumer accepts idx this cycle
//   busy       loop running or finishing
//   done       one-cycle pulse on normal completion
//   dec_a      operand to SDEC, equal to the index register
//   dec_d      result from SDEC, expected to be dec_a - 1

module sdec_loop_seq #(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        start,
  input  logic signed [DATAWIDTH-1:0] count,
  input  logic                        abort,
  output logic signed [DATAWIDTH-1:0] idx,
  output logic                        idx_valid,
  input  logic                        idx_ready,
  output logic                        busy,
  output logic                        done,
  output logic signed [DATAWIDTH-1:0] dec_a,
  input  logic signed [DATAWIDTH-1:0] dec_d
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e                      state_q;
  logic signed [DATAWIDTH-1:0] cur_q;

  // Strictly positive: sign bit clear and not zero. Avoids any mixed-width compare.
  logic count_pos;
  assign count_pos = !count[DATAWIDTH-1] && (count != '0);

  logic cur_is_one;
  assign cur_is_one = (cur_q == DATAWIDTH'(1));

  logic handshake;
  assign handshake = (state_q == StRun) && idx_ready;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StIdle;
      cur_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            if (count_pos) begin
              cur_q   <= count;
              state_q <= StRun;
            end else begin
              cur_q   <= '0;
              state_q <= StDone;
            end
          end
        end
        StRun: begin
          // Abort wins over a same-cycle handshake; that index is dropped.
          if (abort) begin
            cur_q   <= '0;
            state_q <= StIdle;
          end else if (handshake) begin
            if (cur_is_one) begin
              cur_q   <= '0;
              state_q <= StDone;
            end else begin
              cur_q <= dec_d;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          cur_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign idx       = cur_q;
  assign dec_a     = cur_q;
  assign idx_valid = (state_q == StRun);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_sdec_loop_seq.sv
module tb_sdec_loop_seq;

  localparam int unsigned DW = 32;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic signed [DW-1:0] count;
  logic                 abort;
  logic signed [DW-1:0] idx;
  logic                 idx_valid;
  logic                 idx_ready;
  logic                 busy;
  logic                 done;
  logic signed [DW-1:0] dec_a;
  logic signed [DW-1:0] dec_d;

  int total = 0;
  int bad   = 0;

  // SDEC stand-in: d = a - 1.
  assign dec_d = dec_a - 1;

  sdec_loop_seq #(.DATAWIDTH(DW)) dut (
    .Clk      (clk),
    .Rst      (rst),
    .start    (start),
    .count    (count),
    .abort    (abort),
    .idx      (idx),
    .idx_valid(idx_valid),
    .idx_ready(idx_ready),
    .busy     (busy),
    .done     (done),
    .dec_a    (dec_a),
    .dec_d    (dec_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: how many indices remain, whether a loop is live, whether done is due.
  longint m_rem   = 0;
  bit     m_run   = 1'b0;
  bit     m_dpend = 1'b0;

  task automatic model_update();
    if (!rst) begin
      m_rem = 0; m_run = 1'b0; m_dpend = 1'b0;
    end else if (m_dpend) begin
      m_dpend = 1'b0;
    end else if (m_run) begin
      if (abort) begin
        m_run = 1'b0; m_rem = 0;
      end else if (idx_ready) begin
        if (m_rem == 1) begin
          m_run = 1'b0; m_rem = 0; m_dpend = 1'b1;
        end else begin
          m_rem = m_rem - 1;
        end
      end
    end else if (start) begin
      if (longint'(count) > 0) begin
        m_run = 1'b1; m_rem = longint'(count);
      end else begin
        m_dpend = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".idx"},   idx,                    DW'(m_rem));
    chk({tag, ".dec_a"}, dec_a,                  DW'(m_rem));
    chk({tag, ".valid"}, {{(DW-1){1'b0}}, idx_valid}, {{(DW-1){1'b0}}, m_run});
    chk({tag, ".busy"},  {{(DW-1){1'b0}}, busy},  {{(DW-1){1'b0}}, (m_run | m_dpend)});
    chk({tag, ".done"},  {{(DW-1){1'b0}}, done},  {{(DW-1){1'b0}}, m_dpend});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".idx"},   idx,   '0);
    chk({tag, ".dec_a"}, dec_a, '0);
    chk({tag, ".valid"}, {{(DW-1){1'b0}}, idx_valid}, '0);
    chk({tag, ".busy"},  {{(DW-1){1'b0}}, busy},      '0);
    chk({tag, ".done"},  {{(DW-1){1'b0}}, done},      '0);
  endtask

  typedef struct {
    logic          start;
    logic [DW-1:0] count;
    logic          abort;
    logic          ready;
    logic [DW-1:0] e_idx;
    logic          e_valid;
    logic          e_busy;
    logic          e_done;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [DW-1:0] c, input logic a,
                              input logic r, input logic [DW-1:0] ei, input logic ev,
                              input logic eb, input logic ed);
    vec_t v;
    v.start = s; v.count = c; v.abort = a; v.ready = r;
    v.e_idx = ei; v.e_valid = ev; v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    // Table: inputs applied for one edge, outputs expected just after it.
    //                s  count          a  r  idx            v  b  d
    // count=3, ready high
    vecs.push_back(mk(1, 32'd3,         0, 1, 32'd3,         1, 1, 0));
    vecs.push_back(mk(0, 32'd0,         0, 1, 32'd2,         1, 1, 0));
    vecs.push_back(mk(0, 32'd0,         0, 1, 32'd1,         1, 1, 0));
    vecs.push_back(mk(0, 32'd0,         0, 1, 32'd0,         0, 1, 1));
    vecs.push_back(mk(0, 32'd0,         0, 1, 32'd0,         0, 0, 0));
    // count=0 and count=-5: done only
    vecs.push_back(mk(1, 32'd0,         0, 1, 32'd0,         0, 1, 1));
    vecs.push_back(mk(0, 32'd0,         0, 1, 32'd0,         0, 0, 0));
    vecs.push_back(mk(1, -32'sd5,       0, 1, 32'd0,         0, 1, 1));
    vecs.push_back(mk(0, 32'd0,         0, 1, 32'd0,         0, 0, 0));
    // count=2 with backpressure
    vecs.push_back(mk(1, 32'd2,         0, 0, 32'd2,         1, 1, 0));
    vecs.push_back(mk(0, 32'd0,         0, 0, 32'd2,         1, 1, 0));
    vecs.push_back(mk(0, 32'd0,         0, 0, 32'd2,         1, 1, 0));
    vecs.push_back(mk(0, 32'd0,         0, 1, 32'd1,         1, 1, 0));
    vecs.push_back(mk(0, 32'd0,         0, 1, 32'd0,         0, 1, 1));
    vecs.push_back(mk(0, 32'd0,         0, 1, 32'd0,         0, 0, 0));
    // count=5, abort on 2nd index with a same-cycle handshake, then restart
    vecs.push_back(mk(1, 32'd5,         0, 1, 32'd5,         1, 1, 0));
    vecs.push_back(mk(0, 32'd0,         0, 1, 32'd4,         1, 1, 0));
    vecs.push_back(mk(0, 32'd0,         1, 1, 32'd0,         0, 0, 0));
    vecs.push_back(mk(1, 32'd1,         0, 1, 32'd1,         1, 1, 0));
    vecs.push_back(mk(0, 32'd0,         0, 1, 32'd0,         0, 1, 1));
    vecs.push_back(mk(0, 32'd0,         0, 1, 32'd0,         0, 0, 0));
    // start ignored in RUN, start/abort ignored in DONE
    vecs.push_back(mk(1, 32'd2,         0, 0, 32'd2,         1, 1, 0));
    vecs.push_back(mk(1, 32'd9,         0, 1, 32'd1,         1, 1, 0));
    vecs.push_back(mk(1, 32'd9,         0, 1, 32'd0,         0, 1, 1));
    vecs.push_back(mk(1, 32'd4,         1, 1, 32'd0,         0, 0, 0));
    // extremes
    vecs.push_back(mk(1, 32'h7FFFFFFF,  0, 1, 32'h7FFFFFFF,  1, 1, 0));
    vecs.push_back(mk(0, 32'd0,         0, 1, 32'h7FFFFFFE,  1, 1, 0));
    vecs.push_back(mk(0, 32'd0,         1, 0, 32'd0,         0, 0, 0));
    vecs.push_back(mk(1, 32'h80000000,  0, 1, 32'd0,         0, 1, 1));
    vecs.push_back(mk(0, 32'd0,         0, 1, 32'd0,         0, 0, 0));
  end

  initial begin
    rst = 1'b0; start = 1'b0; count = '0; abort = 1'b0; idx_ready = 1'b0;
    #3;
    chk_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk_zero("post_reset");

    // Table-driven vectors
    foreach (vecs[i]) begin
      start = vecs[i].start; count = vecs[i].count;
      abort = vecs[i].abort; idx_ready = vecs[i].ready;
      step();
      chk($sformatf("vec%0d.idx", i),   idx,   vecs[i].e_idx);
      chk($sformatf("vec%0d.dec_a", i), dec_a, vecs[i].e_idx);
      chk($sformatf("vec%0d.valid", i), {{(DW-1){1'b0}}, idx_valid},
          {{(DW-1){1'b0}}, vecs[i].e_valid});
      chk($sformatf("vec%0d.busy", i),  {{(DW-1){1'b0}}, busy},
          {{(DW-1){1'b0}}, vecs[i].e_busy});
      chk($sformatf("vec%0d.done", i),  {{(DW-1){1'b0}}, done},
          {{(DW-1){1'b0}}, vecs[i].e_done});
    end

    // Asynchronous reset mid-RUN, count=7: outputs clear before the next edge
    start = 1'b1; count = 32'd7; abort = 1'b0; idx_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("midrun.idx_before", idx, 32'd6);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("midrun_rst");
    step();
    chk_zero("midrun_rst_held");
    rst = 1'b1;
    step();
    chk_model("after_rst");

    // Randomized run against the reference model
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 249) != 0);
      start     = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 15) == 0);
      idx_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 11))
        0:       count = 32'h7FFFFFFF;
        1:       count = 32'h80000000;
        2:       count = -32'sd1;
        default: count = $signed(DW'($urandom_range(0, 10))) - 32'sd3;
      endcase
      step();
      chk_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
